// File: rtl/branch_redirect_ctrl_if.sv
// Branch-redirect bundle: EX resolution and stall in, PC-mux control out.
// Master is the pipeline side, slave is the redirect controller.
interface branch_redirect_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              ex_br_valid;
    logic              ex_br_taken;
    logic [ADDR_W-1:0] ex_br_target;
    logic              stall_in;
    logic              pc_sel;
    logic [ADDR_W-1:0] pc_target;
    logic              flush_front;
    logic              busy;
    logic [CNT_W-1:0]  redirect_count;

    modport master (
        output ex_br_valid,
        output ex_br_taken,
        output ex_br_target,
        output stall_in,
        input  pc_sel,
        input  pc_target,
        input  flush_front,
        input  busy,
        input  redirect_count
    );

    modport slave (
        input  ex_br_valid,
        input  ex_br_taken,
        input  ex_br_target,
        input  stall_in,
        output pc_sel,
        output pc_target,
        output flush_front,
        output busy,
        output redirect_count
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// PC-source redirect controller with stall hold and wrong-path shadow mask.
// Optional BRANCH_STATS_EN adds a saturating completed-redirect counter.
module branch_redirect_ctrl #(
    parameter int ADDR_W        = 32,
    parameter int SHADOW_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input logic                    clk,
    input logic                    rst,
    branch_redirect_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        SHADOW
    } state_e;

    localparam logic [3:0] SHADOW_INIT = 4'(SHADOW_CYCLES);

    state_e            state_q;
    logic [3:0]        shadow_q;
    logic              pc_sel_q;
    logic              flush_q;
    logic              busy_q;
    logic [ADDR_W-1:0] target_q;
    logic              br_taken;
    logic              exit_redirect;

    assign br_taken      = bus.ex_br_valid && bus.ex_br_taken;
    assign exit_redirect = (state_q == REDIRECT) && !bus.stall_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            pc_sel_q <= 1'b0;
            flush_q  <= 1'b0;
            busy_q   <= 1'b0;
            target_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (br_taken) begin
                        target_q <= bus.ex_br_target;
                        state_q  <= REDIRECT;
                        pc_sel_q <= 1'b1;
                        flush_q  <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                REDIRECT: begin
                    // EX content here is wrong-path; only the stall matters
                    if (!bus.stall_in) begin
                        pc_sel_q <= 1'b0;
                        flush_q  <= 1'b0;
                        if (SHADOW_CYCLES == 0) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            shadow_q <= SHADOW_INIT;
                            state_q  <= SHADOW;
                        end
                    end
                end
                SHADOW: begin
                    if (!bus.stall_in) begin
                        shadow_q <= shadow_q - 4'd1;
                        if (shadow_q == 4'd1) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    pc_sel_q <= 1'b0;
                    flush_q  <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_sel      = pc_sel_q;
    assign bus.flush_front = flush_q;
    assign bus.busy        = busy_q;
    assign bus.pc_target   = target_q;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (exit_redirect && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.redirect_count = cnt_q;
`else
    logic unused_exit;
    assign unused_exit        = exit_redirect;
    assign bus.redirect_count = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: shadow=2 and shadow=0 builds,
// 2-bit stats counter to reach saturation quickly.
module tb_branch_redirect_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        v;
    logic        t;
    logic [31:0] tgt;
    logic        stall;
    int          checks   = 0;
    int          failures = 0;
    int          done     = 0;

    always #5 clk = ~clk;

    branch_redirect_ctrl_if #(.ADDR_W(32), .CNT_W(2)) b2 ();
    branch_redirect_ctrl_if #(.ADDR_W(32), .CNT_W(2)) b0 ();

    assign b2.ex_br_valid  = v;
    assign b2.ex_br_taken  = t;
    assign b2.ex_br_target = tgt;
    assign b2.stall_in     = stall;
    assign b0.ex_br_valid  = v;
    assign b0.ex_br_taken  = t;
    assign b0.ex_br_target = tgt;
    assign b0.stall_in     = stall;

    branch_redirect_ctrl #(
        .ADDR_W(32), .SHADOW_CYCLES(2), .CNT_W(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (b2.slave)
    );

    branch_redirect_ctrl #(
        .ADDR_W(32), .SHADOW_CYCLES(0), .CNT_W(2)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    function automatic logic [63:0] exp_cnt(input int n);
`ifdef BRANCH_STATS_EN
        return (n > 3) ? 64'd3 : 64'(n);
`else
        return 64'd0 + 64'(n * 0);
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic s,
                           input logic f, input logic bz);
        chk({tag, ".pc_sel"}, 64'(b2.pc_sel), 64'(s));
        chk({tag, ".flush"}, 64'(b2.flush_front), 64'(f));
        chk({tag, ".busy"}, 64'(b2.busy), 64'(bz));
    endtask

    initial begin
        rst = 1'b1; v = 1'b1; t = 1'b1;
        tgt = 32'h44; stall = 1'b0;
        step();
        step();
        chk_out("rst", 1'b0, 1'b0, 1'b0);
        chk("rst.target", 64'(b2.pc_target), 64'h0);
        chk("rst.count", 64'(b2.redirect_count), 64'h0);
        chk("rst0.busy", 64'(b0.busy), 64'h0);

        // simple redirect straight after reset release
        rst = 1'b0; tgt = 32'h40;
        step();
        v = 1'b0; t = 1'b0;
        chk_out("simple.c6", 1'b1, 1'b1, 1'b1);
        chk("simple.target", 64'(b2.pc_target), 64'h40);
        chk("simple0.pc_sel", 64'(b0.pc_sel), 64'h1);
        step();
        done = 1;
        chk_out("simple.c7", 1'b0, 1'b0, 1'b1);
        chk("simple0.busy", 64'(b0.busy), 64'h0);
        chk("simple0.pc_sel2", 64'(b0.pc_sel), 64'h0);
        chk("simple.count", 64'(b2.redirect_count), exp_cnt(done));
        step();
        chk_out("simple.c8", 1'b0, 1'b0, 1'b1);
        step();
        chk_out("simple.c9", 1'b0, 1'b0, 1'b0);
        chk("simple.hold", 64'(b2.pc_target), 64'h40);

        // redirect held across a 3-cycle stall, then stalled shadow
        v = 1'b1; t = 1'b1; tgt = 32'h100;
        step();
        v = 1'b0; t = 1'b0; stall = 1'b1;
        chk_out("stall.c4", 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("stall.held", 1'b1, 1'b1, 1'b1);
            chk("stall.target", 64'(b2.pc_target), 64'h100);
        end
        stall = 1'b0;
        step();
        done = 2;
        chk_out("stall.c8", 1'b0, 1'b0, 1'b1);
        chk("stall.count", 64'(b2.redirect_count), exp_cnt(done));
        stall = 1'b1;
        step();
        chk_out("shstall.a", 1'b0, 1'b0, 1'b1);
        stall = 1'b0;
        step();
        chk_out("shstall.b", 1'b0, 1'b0, 1'b1);
        step();
        chk_out("shstall.c", 1'b0, 1'b0, 1'b0);

        // wrong-path taken branches masked in REDIRECT and SHADOW
        v = 1'b1; t = 1'b1; tgt = 32'h80;
        step();
        tgt = 32'h200;
        chk_out("mask.c3", 1'b1, 1'b1, 1'b1);
        step();
        done = 3;
        chk_out("mask.c4", 1'b0, 1'b0, 1'b1);
        step();
        chk_out("mask.c5", 1'b0, 1'b0, 1'b1);
        step();
        chk_out("mask.c6", 1'b0, 1'b0, 1'b0);
        chk("mask.target", 64'(b2.pc_target), 64'h80);
        chk("mask.count", 64'(b2.redirect_count), exp_cnt(done));
        tgt = 32'h300;
        step();
        v = 1'b0; t = 1'b0;
        chk_out("mask.accept", 1'b1, 1'b1, 1'b1);
        chk("mask.newtgt", 64'(b2.pc_target), 64'h300);
        step();
        done = 4;
        step();
        step();
        chk_out("mask.idle", 1'b0, 1'b0, 1'b0);
        chk("sat.count4", 64'(b2.redirect_count), exp_cnt(done));

        // not-taken and taken-without-valid are ignored
        v = 1'b1; t = 1'b0; tgt = 32'h777;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_out("nt", 1'b0, 1'b0, 1'b0);
        end
        v = 1'b0; t = 1'b1;
        step();
        step();
        chk_out("noval", 1'b0, 1'b0, 1'b0);
        chk("nt.target", 64'(b2.pc_target), 64'h300);
        chk("nt.count", 64'(b2.redirect_count), exp_cnt(done));

        // fifth redirect, then reset in a stalled REDIRECT
        v = 1'b1; t = 1'b1; tgt = 32'h5a0;
        step();
        v = 1'b0; t = 1'b0;
        step();
        done = 5;
        step();
        step();
        chk_out("r5.idle", 1'b0, 1'b0, 1'b0);
        chk("sat.count5", 64'(b2.redirect_count), exp_cnt(done));
        v = 1'b1; t = 1'b1; tgt = 32'habc0;
        step();
        stall = 1'b1;
        chk_out("r6.c1", 1'b1, 1'b1, 1'b1);
        step();
        chk_out("r6.c2", 1'b1, 1'b1, 1'b1);
        chk("r6.target", 64'(b2.pc_target), 64'habc0);
        rst = 1'b1;
        step();
        chk_out("midrst", 1'b0, 1'b0, 1'b0);
        chk("midrst.target", 64'(b2.pc_target), 64'h0);
        chk("midrst.count", 64'(b2.redirect_count), 64'h0);
        chk("midrst0.pc_sel", 64'(b0.pc_sel), 64'h0);
        chk("midrst0.busy", 64'(b0.busy), 64'h0);
        rst = 1'b0; stall = 1'b0; tgt = 32'h1230;
        step();
        v = 1'b0; t = 1'b0;
        chk_out("post", 1'b1, 1'b1, 1'b1);
        chk("post.target", 64'(b2.pc_target), 64'h1230);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Control stage that drives the single-bit PC-source select feeding the 2:1 PC mux in the 6-stage pipeline (IF, ID, RF, EX, MEM, WB).
- Select behaviour: in0 = sequential PC, in1 = redirect target; pc_sel = 1 picks in1.
- Watches resolved branches from EX and holds the redirect across front-end stalls.
- Squashes wrong-path instructions in IF/ID/RF, then masks wrong-path branch resolutions for a fixed shadow window.

Parameters:
- ADDR_W, 32, width of branch target / PC.
- SHADOW_CYCLES, 2, cycles after redirect during which ex_br_valid is ignored; legal range 0..15.
- CNT_W, 16, width of redirect statistics counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- ex_br_valid  input  1  EX stage holds a resolved control-transfer instruction this cycle.
- ex_br_taken  input  1  resolved direction; qualified by ex_br_valid.
- ex_br_target  input  ADDR_W  resolved target; qualified by ex_br_valid.
- stall_in  input  1  front-end freeze from hazard unit; PC does not update while high.
- pc_sel  output  1  select to PC 2:1 mux; 1 = load pc_target.
- pc_target  output  ADDR_W  redirect address presented to mux in1.
- flush_front  output  1  squash IF/ID/RF pipeline registers.
- busy  output  1  high in any state other than IDLE.
- redirect_count  output  CNT_W  number of completed redirects (see Optional Feature).

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst. All outputs are registered.
- Reset values: pc_sel=0, pc_target=0, flush_front=0, busy=0, redirect_count=0, state=IDLE, shadow counter=0.
- rst has priority over every other input in the same cycle, including mid-REDIRECT and mid-SHADOW.
- States: IDLE, REDIRECT, SHADOW.
- IDLE:
  - If ex_br_valid && ex_br_taken at edge t, latch ex_br_target into pc_target and go to REDIRECT.
  - From edge t+1: pc_sel=1, flush_front=1, busy=1. Latency is 1 cycle.
  - If ex_br_valid && !ex_br_taken: no action.
  - ex_br_taken without ex_br_valid: ignored.
- REDIRECT:
  - pc_sel=1, flush_front=1, pc_target held stable.
  - While stall_in=1, remain in REDIRECT with outputs unchanged; the redirect is not lost.
  - On the first edge with stall_in=0, the redirect is consumed.
  - If SHADOW_CYCLES=0, go to IDLE. Otherwise load the shadow counter with SHADOW_CYCLES and go to SHADOW.
  - pc_sel and flush_front drop in the next cycle.
  - ex_br_valid is ignored in REDIRECT (wrong path).
- SHADOW:
  - pc_sel=0, flush_front=0, busy=1. ex_br_valid/ex_br_taken are ignored.
  - Counter decrements only on edges with stall_in=0.
  - When the counter is 1 and stall_in=0, go to IDLE at that edge.
  - A taken branch arriving in the same cycle as the SHADOW->IDLE transition is ignored. A taken branch in the first IDLE cycle is accepted.
- pc_target changes only on IDLE->REDIRECT. It retains its value otherwise, so in0/in1 selection glitches cannot occur.
- Back-to-back taken branches: the second is accepted only once state is IDLE.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined:
  - redirect_count increments by 1 on every REDIRECT exit (stall_in=0 edge in REDIRECT).
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by rst.
- Undefined:
  - Counter logic is absent and redirect_count is tied to 0.
  - All other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with ex_br_valid=1, ex_br_taken=1 -> all outputs 0, state IDLE; after release, first taken branch is accepted normally.
- Simple redirect, SHADOW_CYCLES=2: taken branch target 0x0000_0040 at cycle 5, no stall -> pc_sel=1, flush_front=1, pc_target=0x40 in cycle 6 only; busy high cycles 6-8; idle from cycle 9.
- Stall during redirect: taken branch target 0x100 at cycle 3, stall_in=1 cycles 4-6 -> pc_sel=1 and pc_target=0x100 held cycles 4-7, deassert in cycle 8; redirect_count=1 (stats build).
- Shadow masking: taken branch target 0x80 at cycle 2, second taken branch target 0x200 at cycles 3, 4 and 5 -> only the first redirect occurs, pc_target stays 0x80, count=1; a taken branch at cycle 6 (first IDLE cycle) is accepted.
- Not-taken: ex_br_valid=1, ex_br_taken=0 for 10 cycles -> pc_sel, flush_front, busy stay 0; count unchanged.
- Reset mid-operation: rst asserted in the second REDIRECT cycle while stall_in=1 -> next cycle all outputs 0, IDLE; stats counter saturation checked with CNT_W=2 after 5 redirects -> redirect_count=3.
